// File: rtl/accel_config_issuer_if.sv
// Descriptor handshake bundle between the layer-list controller and the
// Accel configuration issuer.
interface accel_config_issuer_if;
  logic        desc_valid;
  logic        desc_ready;
  logic [7:0]  desc_image_dim;
  logic [8:0]  desc_image_depth;
  logic [19:0] desc_image_offset;
  logic [19:0] desc_filter_offset;
  logic [19:0] desc_output_offset;
  logic [1:0]  desc_filter_halfsize;
  logic [2:0]  desc_filter_stride;
  logic [12:0] desc_filter_length;
  logic [17:0] desc_filter_bias;
  logic [18:0] desc_interrupt;

  modport master (
    output desc_valid,
    output desc_image_dim,
    output desc_image_depth,
    output desc_image_offset,
    output desc_filter_offset,
    output desc_output_offset,
    output desc_filter_halfsize,
    output desc_filter_stride,
    output desc_filter_length,
    output desc_filter_bias,
    output desc_interrupt,
    input  desc_ready
  );

  modport slave (
    input  desc_valid,
    input  desc_image_dim,
    input  desc_image_depth,
    input  desc_image_offset,
    input  desc_filter_offset,
    input  desc_output_offset,
    input  desc_filter_halfsize,
    input  desc_filter_stride,
    input  desc_filter_length,
    input  desc_filter_bias,
    input  desc_interrupt,
    output desc_ready
  );
endinterface

// File: rtl/accel_config_issuer.sv
// Sequencer that resets Accel, streams ten config writes plus a trigger,
// then waits for accel_done (or a timeout) and reports completion.
module accel_config_issuer #(
  parameter int DONE_GUARD     = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  accel_config_issuer_if.slave        desc,
  input  logic                        abort,
  input  logic                        accel_done,
  output logic [31:0]                 instruction,
  output logic                        accel_rst_ext,
  output logic                        busy,
  output logic                        layer_done,
  output logic                        layer_error
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [23:0] G_LAST = 24'(DONE_GUARD - 1);
  localparam logic [23:0] TO = 24'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, RST, CFG, TRIG, GUARD, WAIT
  } state_t;

  typedef struct packed {
    logic [7:0]  dim;
    logic [8:0]  depth;
    logic [19:0] img;
    logic [19:0] flt;
    logic [19:0] outp;
    logic [1:0]  half;
    logic [2:0]  stride;
    logic [12:0] len;
    logic [17:0] bias;
    logic [18:0] intr;
  } desc_t;

  state_t      state;
  desc_t       d;
  logic [3:0]  idx;
  logic [3:0]  sel;
  logic [19:0] imm;
  logic [23:0] cnt;
  logic [23:0] cnt_nx;

  function automatic logic [31:0] enc(
    input logic [4:0]  rd,
    input logic [19:0] val
  );
    return {val, rd, 7'b0001011};
  endfunction

  // sel is the index of the write being placed on the bus at this edge
  assign sel    = (state == CFG) ? idx + 4'd1 : 4'd0;
  assign cnt_nx = cnt + 24'd1;

  always_comb begin
    imm = '0;
    case (sel)
      4'd0:    imm = {12'd0, d.dim};
      4'd1:    imm = {11'd0, d.depth};
      4'd2:    imm = d.img;
      4'd3:    imm = d.flt;
      4'd4:    imm = d.outp;
      4'd5:    imm = {18'd0, d.half};
      4'd6:    imm = {17'd0, d.stride};
      4'd7:    imm = {7'd0, d.len};
      4'd8:    imm = {2'd0, d.bias};
      4'd9:    imm = {1'b0, d.intr};
      default: imm = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      d               <= '0;
      idx             <= '0;
      cnt             <= '0;
      instruction     <= NOP;
      accel_rst_ext   <= 1'b1;
      desc.desc_ready <= 1'b0;
      busy            <= 1'b0;
      layer_done      <= 1'b0;
      layer_error     <= 1'b0;
    end else begin
      instruction   <= NOP;
      accel_rst_ext <= 1'b0;
      layer_done    <= 1'b0;
      layer_error   <= 1'b0;
      if (state != IDLE && abort) begin
        state           <= IDLE;
        accel_rst_ext   <= 1'b1;
        busy            <= 1'b0;
        desc.desc_ready <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            desc.desc_ready <= 1'b1;
            busy            <= 1'b0;
            if (desc.desc_valid && desc.desc_ready) begin
              d <= '{
                dim:    desc.desc_image_dim,
                depth:  desc.desc_image_depth,
                img:    desc.desc_image_offset,
                flt:    desc.desc_filter_offset,
                outp:   desc.desc_output_offset,
                half:   desc.desc_filter_halfsize,
                stride: desc.desc_filter_stride,
                len:    desc.desc_filter_length,
                bias:   desc.desc_filter_bias,
                intr:   desc.desc_interrupt
              };
              state           <= RST;
              desc.desc_ready <= 1'b0;
              busy            <= 1'b1;
              accel_rst_ext   <= 1'b1;
            end
          end
          RST: begin
            state       <= CFG;
            idx         <= 4'd0;
            instruction <= enc({1'b0, sel}, imm);
          end
          CFG: begin
            if (idx == 4'd9) begin
              state       <= TRIG;
              instruction <= enc(5'h1F, 20'd0);
            end else begin
              idx         <= sel;
              instruction <= enc({1'b0, sel}, imm);
            end
          end
          TRIG: begin
            state <= GUARD;
            cnt   <= '0;
          end
          GUARD: begin
            if (cnt == G_LAST) begin
              state <= WAIT;
              cnt   <= '0;
            end else begin
              cnt <= cnt_nx;
            end
          end
          WAIT: begin
            cnt <= cnt_nx;
            if (accel_done) begin
              state      <= IDLE;
              busy       <= 1'b0;
              layer_done <= 1'b1;
            end else if (TO != 24'd0 && cnt_nx >= TO) begin
              state         <= IDLE;
              busy          <= 1'b0;
              layer_done    <= 1'b1;
              layer_error   <= 1'b1;
              accel_rst_ext <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accel_config_issuer.sv
// Directed bench for accel_config_issuer: config stream, done guard,
// timeout, abort and asynchronous reset.
module tb_accel_config_issuer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        abort;
  logic        accel_done;
  logic [31:0] instruction;
  logic        accel_rst_ext;
  logic        busy;
  logic        layer_done;
  logic        layer_error;

  int n_chk;
  int n_pass;

  logic [31:0] exp_cfg [10];

  accel_config_issuer_if dif ();

  accel_config_issuer #(
    .DONE_GUARD     (2),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .desc          (dif.slave),
    .abort         (abort),
    .accel_done    (accel_done),
    .instruction   (instruction),
    .accel_rst_ext (accel_rst_ext),
    .busy          (busy),
    .layer_done    (layer_done),
    .layer_error   (layer_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input logic [7:0] dim);
    dif.desc_image_dim       = dim;
    dif.desc_image_depth     = 9'd3;
    dif.desc_image_offset    = 20'h12345;
    dif.desc_filter_offset   = 20'hABCDE;
    dif.desc_output_offset   = 20'h00F0F;
    dif.desc_filter_halfsize = 2'd2;
    dif.desc_filter_stride   = 3'd5;
    dif.desc_filter_length   = 13'h1ABC;
    dif.desc_filter_bias     = 18'h3FFFF;
    dif.desc_interrupt       = 19'h7FFFF;
  endtask

  task automatic send(input logic [7:0] dim);
    set_desc(dim);
    chk("send_ready", {31'd0, dif.desc_ready}, 32'd1);
    dif.desc_valid = 1'b1;
    tick();
    dif.desc_valid = 1'b0;
    set_desc(8'h55);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    exp_cfg[0] = 32'h0002000B;
    exp_cfg[1] = 32'h0000308B;
    exp_cfg[2] = 32'h1234510B;
    exp_cfg[3] = 32'hABCDE18B;
    exp_cfg[4] = 32'h00F0F20B;
    exp_cfg[5] = 32'h0000228B;
    exp_cfg[6] = 32'h0000530B;
    exp_cfg[7] = 32'h01ABC38B;
    exp_cfg[8] = 32'h3FFFF40B;
    exp_cfg[9] = 32'h7FFFF48B;

    rst            = 1'b1;
    abort          = 1'b0;
    accel_done     = 1'b0;
    dif.desc_valid = 1'b0;
    set_desc(8'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst_instr", instruction, NOP);
    chk("rst_ext", {31'd0, accel_rst_ext}, 32'd1);
    chk("rst_ready", {31'd0, dif.desc_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, layer_done}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("idle_ready", {31'd0, dif.desc_ready}, 32'd1);
    chk("idle_ext", {31'd0, accel_rst_ext}, 32'd0);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_ready", {31'd0, dif.desc_ready}, 32'd1);
    chk("idle_abort_ext", {31'd0, accel_rst_ext}, 32'd0);

    // layer 1: done held high from the start
    accel_done = 1'b1;
    send(8'd32);
    chk("t1_ext", {31'd0, accel_rst_ext}, 32'd1);
    chk("t1_instr", instruction, NOP);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_ready", {31'd0, dif.desc_ready}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("cfg%0d", i), instruction, exp_cfg[i]);
      chk($sformatf("cfg%0d_ext", i), {31'd0, accel_rst_ext}, 32'd0);
    end
    tick();
    chk("trig", instruction, 32'h00000F8B);
    tick();
    chk("guard1_done", {31'd0, layer_done}, 32'd0);
    chk("guard1_instr", instruction, NOP);
    tick();
    chk("guard2_done", {31'd0, layer_done}, 32'd0);
    tick();
    chk("wait1_done", {31'd0, layer_done}, 32'd0);
    chk("wait1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("done_pulse", {31'd0, layer_done}, 32'd1);
    chk("done_err", {31'd0, layer_error}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_ext", {31'd0, accel_rst_ext}, 32'd0);
    chk("done_ready", {31'd0, dif.desc_ready}, 32'd0);
    tick();
    chk("after_done", {31'd0, layer_done}, 32'd0);
    chk("after_ready", {31'd0, dif.desc_ready}, 32'd1);
    accel_done = 1'b0;

    // layer 2: timeout after 10 WAIT cycles
    send(8'd32);
    repeat (14) tick();
    chk("to_wait_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k < 10; k++) begin
      tick();
      chk($sformatf("to_early%0d", k), {31'd0, layer_done}, 32'd0);
    end
    tick();
    chk("to_done", {31'd0, layer_done}, 32'd1);
    chk("to_err", {31'd0, layer_error}, 32'd1);
    chk("to_ext", {31'd0, accel_rst_ext}, 32'd1);
    chk("to_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("to_after_done", {31'd0, layer_done}, 32'd0);
    chk("to_after_ext", {31'd0, accel_rst_ext}, 32'd0);
    chk("to_after_ready", {31'd0, dif.desc_ready}, 32'd1);

    // layer 3: abort while CFG index 4 is on the bus
    send(8'd32);
    repeat (5) tick();
    chk("ab_cfg4", instruction, exp_cfg[4]);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_instr", instruction, NOP);
    chk("ab_ext", {31'd0, accel_rst_ext}, 32'd1);
    chk("ab_done", {31'd0, layer_done}, 32'd0);
    tick();
    chk("ab_ext_off", {31'd0, accel_rst_ext}, 32'd0);
    chk("ab_done2", {31'd0, layer_done}, 32'd0);
    chk("ab_ready", {31'd0, dif.desc_ready}, 32'd1);

    // layer 4: restart from rd 0, then reset in WAIT
    send(8'hFF);
    tick();
    chk("re_cfg0", instruction, 32'h000FF00B);
    tick();
    chk("re_cfg1", instruction, exp_cfg[1]);
    repeat (14) tick();
    chk("rw_busy", {31'd0, busy}, 32'd1);
    chk("rw_done", {31'd0, layer_done}, 32'd0);
    #3 rst = 1'b0;
    #1;
    chk("ar_instr", instruction, NOP);
    chk("ar_ext", {31'd0, accel_rst_ext}, 32'd1);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_ready", {31'd0, dif.desc_ready}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("ar_rel_ready", {31'd0, dif.desc_ready}, 32'd1);
    chk("ar_rel_ext", {31'd0, accel_rst_ext}, 32'd0);
    chk("ar_rel_busy", {31'd0, busy}, 32'd0);
    chk("ar_rel_instr", instruction, NOP);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/accel_config_issuer.md
Name: accel_config_issuer

Overview:
Host-side sequencer that drives the Accel custom-instruction port. It accepts one layer descriptor through a valid/ready handshake and pulses the accel's external reset. It then emits the ten EXTEND_OPCODE configuration writes and the trigger instruction, waits for accel_done, and reports layer completion (or timeout) upstream. It is the transmitter for the accel's instruction decoder and sits between the layer-list controller and Accel.

Parameters:
DONE_GUARD, 2, cycles after the trigger during which accel_done is ignored (stale-done filter); 1..15.
TIMEOUT_CYCLES, 0, maximum cycles in WAIT before error; 0 disables the timeout; counter is 24 bits.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
desc_valid  in  1  descriptor offered
desc_ready  out  1  issuer can accept a descriptor
desc_image_dim  in  8  image dimension
desc_image_depth  in  9  image depth
desc_image_offset  in  20  image memory base
desc_filter_offset  in  20  filter memory base
desc_output_offset  in  20  output memory base
desc_filter_halfsize  in  2  filter halfsize / padding
desc_filter_stride  in  3  stride
desc_filter_length  in  13  filter length
desc_filter_bias  in  18  bias
desc_interrupt  in  19  interrupt word
abort  in  1  synchronous abort of the current layer
accel_done  in  1  Accel done
instruction  out  32  instruction to Accel
accel_rst_ext  out  1  Accel external reset, active-high
busy  out  1  layer in progress
layer_done  out  1  one-cycle completion pulse
layer_error  out  1  qualifies layer_done: 1 = timeout

Behaviour:
- Encoding: instruction = {imm[19:0], rd[4:0], 7'b0001011}. Each field is zero-extended into imm. NOP = 32'h00000013.
- All outputs are registered.
- Reset (rst=0): state IDLE; instruction=NOP; accel_rst_ext=1; desc_ready=0; busy=0; layer_done=0; layer_error=0. The descriptor registers are cleared.
- IDLE:
  - desc_ready=1, accel_rst_ext=0, instruction=NOP.
  - desc_valid&desc_ready at edge T latches all fields and moves to RST. Descriptor inputs are ignored outside IDLE.
- RST: single cycle. Cycle T+1 drives accel_rst_ext=1, instruction=NOP, busy=1.
- CFG: cycles T+2..T+11 emit rd 0x00..0x09 in ascending order. Field order is dim, depth, image_off, filter_off, output_off, halfsize, stride, length, bias, interrupt. A 4-bit index counts the writes.
- TRIG: cycle T+12 emits rd 0x1F, imm=0.
- GUARD: NOP for DONE_GUARD cycles; accel_done is ignored.
- WAIT:
  - NOP; the timeout counter increments each cycle.
  - If accel_done=1, pulse layer_done=1 with layer_error=0 and go to IDLE.
  - Else if TIMEOUT_CYCLES!=0 and the counter has reached TIMEOUT_CYCLES, pulse layer_done=1 with layer_error=1, drive accel_rst_ext=1 for that cycle, and go to IDLE.
  - accel_done takes priority over timeout in the same cycle.
- busy=1 in RST, CFG, TRIG, GUARD and WAIT; busy=0 in IDLE.
- abort=1 in any non-IDLE state: next cycle instruction=NOP and accel_rst_ext=1 (one cycle), then IDLE. No layer_done pulse. abort in IDLE is ignored.
- abort has priority over accel_done and timeout.
- desc_ready re-asserts the cycle after return to IDLE. Back-to-back descriptors are therefore separated by at least one idle cycle.
- Asynchronous reset mid-operation returns immediately to reset values; no partial sequence is resumed.

Test Plan:
- Single layer, dim=32 and depth=3: T+1 accel_rst_ext=1. T+2 instruction=0x0002000B. T+3 instruction=0x0000308B. T+12 instruction=0x00000F8B.
- accel_done held at 1 throughout, DONE_GUARD=2: the done is ignored through guard. layer_done pulses exactly once at the first WAIT cycle with layer_error=0. desc_ready=1 the following cycle.
- TIMEOUT_CYCLES=10, accel_done held at 0: layer_done=1, layer_error=1 and accel_rst_ext=1 exactly 10 WAIT cycles after entering WAIT, then IDLE.
- abort during CFG index 4: the next instruction is NOP with accel_rst_ext=1 for one cycle, then IDLE. No layer_done. A new descriptor restarts from rd 0x00.
- filter_bias=18'h3FFFF, interrupt=19'h7FFFF: emitted words are 0x3FFFF40B and 0x7FFFF48B; upper imm bits are zero.
- rst low during WAIT: instruction=NOP, accel_rst_ext=1, busy=0 without a clock edge. After release, state is IDLE with desc_ready=1.
